// File: rtl/half_subtractor_unit.sv
`default_nettype none
// =============================================================================
// half_subtractor_unit : registered half-subtractor bank, optional word-chained
// Revision 1.0
// =============================================================================
module half_subtractor_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Difference,
  output logic [WIDTH-1:0] Borrow,
  output logic             borrow_any,
  output logic             word_borrow
);

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_bor;
  logic             w_bin;

  logic             r_valid;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] r_bor;
  logic             r_any;
  logic             r_wb;

  // Lane mode forces every borrow-in to 0, so the full-subtract equations
  // collapse to the independent half-subtract ones.
  always_comb begin
    w_diff = '0;
    w_bor  = '0;
    w_bin  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_diff[i] = A[i] ^ B[i] ^ w_bin;
      w_bor[i]  = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & w_bin);
      w_bin     = mode & w_bor[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_diff  <= '0;
      r_bor   <= '0;
      r_any   <= 1'b0;
      r_wb    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_diff <= w_diff;
        r_bor  <= w_bor;
        r_any  <= |w_bor;
        r_wb   <= mode & w_bor[WIDTH-1];
      end
    end
  end

  assign out_valid   = r_valid;
  assign Difference  = r_diff;
  assign Borrow      = r_bor;
  assign borrow_any  = r_any;
  assign word_borrow = r_wb;

endmodule
`default_nettype wire

// File: tb/tb_half_subtractor_unit.sv
`default_nettype none
// =============================================================================
// tb_half_subtractor_unit : randomized + directed bench for WIDTH=1 and WIDTH=8
// Revision 1.0
// =============================================================================
module tb_half_subtractor_unit;

  typedef struct packed {
    logic        ov;
    logic [63:0] d;
    logic [63:0] b;
    logic        any;
    logic        wb;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v1 = 1'b0, m1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ov1, any1, wb1;
  logic [0:0] dif1, bor1;

  logic       v8 = 1'b0, m8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ov8, any8, wb8;
  logic [7:0] dif8, bor8;

  half_subtractor_unit #(.WIDTH(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(v1), .mode(m1), .A(a1), .B(b1),
    .out_valid(ov1), .Difference(dif1), .Borrow(bor1),
    .borrow_any(any1), .word_borrow(wb1));

  half_subtractor_unit #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(v8), .mode(m8), .A(a8), .B(b8),
    .out_valid(ov8), .Difference(dif8), .Borrow(bor8),
    .borrow_any(any8), .word_borrow(wb8));

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Arithmetic reference: in word mode, lane i borrows out exactly when the
  // low i+1 bits of A are smaller than the low i+1 bits of B.
  function automatic res_t model(int w, logic m, logic [63:0] a, logic [63:0] b);
    res_t r;
    logic [63:0] mask, mi;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a & mask;
    b = b & mask;
    r = '0;
    r.ov = 1'b1;
    if (!m) begin
      r.d = a ^ b;
      r.b = ~a & b & mask;
    end else begin
      r.d = (a - b) & mask;
      for (int i = 0; i < w; i++) begin
        mi = (i == 63) ? '1 : ((64'd1 << (i + 1)) - 64'd1);
        r.b[i] = ((a & mi) < (b & mi));
      end
      r.wb = (a < b);
    end
    r.any = |r.b;
    return r;
  endfunction

  res_t e1 = '0, e8 = '0;

  always @(posedge clk) begin
    if (rst) begin
      e1 <= '0;
      e8 <= '0;
    end else begin
      if (v1) e1 <= model(1, m1, {63'd0, a1}, {63'd0, b1});
      else    e1.ov <= 1'b0;
      if (v8) e8 <= model(8, m8, {56'd0, a8}, {56'd0, b8});
      else    e8.ov <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ({ov1, dif1, bor1, any1, wb1} !== {e1.ov, e1.d[0], e1.b[0], e1.any, e1.wb}) begin
        n_err++;
        $display("FAIL model_w1 t=%0t got ov=%b d=%b b=%b any=%b wb=%b want ov=%b d=%b b=%b any=%b wb=%b",
                 $time, ov1, dif1, bor1, any1, wb1, e1.ov, e1.d[0], e1.b[0], e1.any, e1.wb);
      end
      n_vec++;
      if ({ov8, dif8, bor8, any8, wb8} !== {e8.ov, e8.d[7:0], e8.b[7:0], e8.any, e8.wb}) begin
        n_err++;
        $display("FAIL model_w8 t=%0t got ov=%b d=%h b=%h any=%b wb=%b want ov=%b d=%h b=%h any=%b wb=%b",
                 $time, ov8, dif8, bor8, any8, wb8, e8.ov, e8.d[7:0], e8.b[7:0], e8.any, e8.wb);
      end
    end
  end

  task automatic drv1(input logic v, input logic m, input logic a, input logic b);
    @(posedge clk); #1;
    v1 = v; m1 = m; a1 = a; b1 = b;
  endtask

  task automatic drv8(input logic v, input logic m, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    v8 = v; m8 = m; a8 = a; b8 = b;
  endtask

  // Literal checks sample just after the falling edge to stay clear of the model compare.
  task automatic lit1(input string nm, input logic [4:0] want);
    @(negedge clk); #1;
    n_vec++;
    if ({ov1, dif1, bor1, any1, wb1} !== want) begin
      n_err++;
      $display("FAIL %s got {ov,d,b,any,wb}=%b want %b", nm, {ov1, dif1, bor1, any1, wb1}, want);
    end
  endtask

  task automatic lit8(input string nm, input logic ov, input logic [7:0] d,
                      input logic [7:0] b, input logic any, input logic wb);
    @(negedge clk); #1;
    n_vec++;
    if ({ov8, dif8, bor8, any8, wb8} !== {ov, d, b, any, wb}) begin
      n_err++;
      $display("FAIL %s got ov=%b d=%h b=%h any=%b wb=%b want ov=%b d=%h b=%h any=%b wb=%b",
               nm, ov8, dif8, bor8, any8, wb8, ov, d, b, any, wb);
    end
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk_en = 1'b1;
    lit8("reset_w8", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    lit1("reset_w1", 5'b00000);
    rst = 1'b0;

    // WIDTH=1 lane-mode truth table, back-to-back
    drv1(1, 0, 0, 0);
    drv1(1, 0, 1, 0); lit1("w1_00", 5'b10000);
    drv1(1, 0, 0, 1); lit1("w1_10", 5'b11000);
    drv1(1, 0, 1, 1); lit1("w1_01", 5'b11110);
    drv1(0, 0, 0, 0); lit1("w1_11", 5'b10000);
    drv1(1, 1, 0, 1); drv1(0, 0, 0, 0); lit1("w1_word_01", 5'b11111);

    // WIDTH=8 lane and word directed cases
    drv8(1, 0, 8'h0F, 8'hF0); drv8(0, 0, 8'h00, 8'h00);
    lit8("lane_0F_F0", 1, 8'hFF, 8'hF0, 1, 0);
    drv8(1, 1, 8'h05, 8'h03); drv8(0, 0, 8'h00, 8'h00);
    lit8("word_05_03", 1, 8'h02, 8'h02, 1, 0);
    drv8(1, 1, 8'h03, 8'h05); drv8(0, 0, 8'h00, 8'h00);
    lit8("word_03_05", 1, 8'hFE, 8'hFC, 1, 1);
    drv8(1, 1, 8'h00, 8'h01); drv8(0, 0, 8'h00, 8'h00);
    lit8("word_00_01", 1, 8'hFF, 8'hFF, 1, 1);

    // Hold: outputs frozen while in_valid=0 and operands wander
    drv8(1, 1, 8'h03, 8'h05);
    for (int k = 0; k < 3; k++) begin
      drv8(0, $urandom_range(0, 1), 8'($urandom), 8'($urandom));
      lit8("hold", (k == 0), 8'hFE, 8'hFC, 1, 1);
    end

    // Reset mid-stream with a valid op on the same edge
    drv8(1, 0, 8'hA5, 8'h3C);
    @(posedge clk); #1;
    rst = 1'b1; v8 = 1'b1; m8 = 1'b0; a8 = 8'h00; b8 = 8'h01;
    @(posedge clk); #1;
    rst = 1'b0; v8 = 1'b0;
    lit8("reset_mid", 0, 8'h00, 8'h00, 0, 0);
    drv8(1, 1, 8'h05, 8'h03);
    lit8("post_rst_idle", 0, 8'h00, 8'h00, 0, 0);
    drv8(0, 0, 8'h00, 8'h00);
    lit8("post_rst_first", 1, 8'h02, 8'h02, 1, 0);

    // Throughput: back-to-back random ops on both instances
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      v8 = 1'b1; m8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); b8 = 8'($urandom);
      v1 = 1'b1; m1 = 1'($urandom_range(0, 1)); a1 = 1'($urandom); b1 = 1'($urandom);
    end
    @(posedge clk); #1;
    v8 = 1'b0; v1 = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    // Random valid/idle mix
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      v8 = 1'($urandom_range(0, 1)); m8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); b8 = 8'($urandom);
      v1 = 1'($urandom_range(0, 1)); m1 = 1'($urandom_range(0, 1)); a1 = 1'($urandom); b1 = 1'($urandom);
    end
    @(posedge clk); @(posedge clk); #1;
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
